// File: rtl/arcade_input_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_pkg
// Description : Shared constants for the arcade input controller: PS/2
//               scancodes, key-state vector indices, joystick bit indices
//               and the coin/start sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package arcade_input_pkg;

    // Scancodes matched on the low 8 bits only (extended flag ignored)
    localparam logic [7:0] c_sc_up    = 8'h75;
    localparam logic [7:0] c_sc_down  = 8'h72;
    localparam logic [7:0] c_sc_left  = 8'h6B;
    localparam logic [7:0] c_sc_right = 8'h74;
    localparam logic [7:0] c_sc_ctrl  = 8'h14;

    // Scancodes matched together with the extended flag (must be non-extended)
    localparam logic [8:0] c_sc_space = 9'h029;
    localparam logic [8:0] c_sc_f1    = 9'h005;
    localparam logic [8:0] c_sc_f2    = 9'h006;
    localparam logic [8:0] c_sc_f3    = 9'h004;

    // Bit positions inside the key-state vector
    localparam int c_key_up    = 0;
    localparam int c_key_down  = 1;
    localparam int c_key_left  = 2;
    localparam int c_key_right = 3;
    localparam int c_key_ctrl  = 4;
    localparam int c_key_space = 5;
    localparam int c_key_f1    = 6;
    localparam int c_key_f2    = 7;
    localparam int c_key_count = 8;

    // Joystick bit positions
    localparam int c_joy_right   = 0;
    localparam int c_joy_left    = 1;
    localparam int c_joy_down    = 2;
    localparam int c_joy_up      = 3;
    localparam int c_joy_fire    = 4;
    localparam int c_joy_barrier = 5;
    localparam int c_joy_start1  = 6;
    localparam int c_joy_start2  = 7;

    // Coin/start sequencer states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COIN    = 3'd1,
        ST_GAP     = 3'd2,
        ST_START   = 3'd3,
        ST_RELEASE = 3'd4
    } seq_state_t;

    // Larger of two integers, used to size the shared sequencer counter
    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arcade_input_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_ctrl_if
// Description : Bundle of the keyboard/joystick inputs and game-control
//               outputs of the arcade input controller. The slave modport is
//               the controller side, the master modport the driving side.
// Revision    : 1.0 - initial release
// ============================================================================
interface arcade_input_ctrl_if;

    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;

    logic        btn_left;
    logic        btn_right;
    logic        btn_fire;
    logic        btn_barrier;
    logic        btn_coin;
    logic [1:0]  btn_player_start;
    logic        seq_busy;

    modport master (
        output ps2_key, joystick_0, joystick_1, rotate,
        input  btn_left, btn_right, btn_fire, btn_barrier, btn_coin,
               btn_player_start, seq_busy
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1, rotate,
        output btn_left, btn_right, btn_fire, btn_barrier, btn_coin,
               btn_player_start, seq_busy
    );

endinterface
`default_nettype wire

// File: rtl/arcade_input_ctrl_ps2_keys.sv
`default_nettype none
// ============================================================================
// Module      : arcade_ps2_keys
// Description : Detects PS/2 key events from the toggle bit and keeps a
//               held/released state per game key. Optional F3 press pulse
//               when ARCADE_AUTOFIRE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module arcade_ps2_keys
    import arcade_input_pkg::*;
(
    input  wire logic                   clk_sys,
    input  wire logic                   reset_n,
    input  wire logic [10:0]            ps2_key,
`ifdef ARCADE_AUTOFIRE_EN
    output logic                        f3_press,
`endif
    output logic [c_key_count-1:0]      key_state
);

    logic                   r_toggle_q;
    logic                   r_armed;
    logic [c_key_count-1:0] r_key_state;
    logic                   w_event;
    logic                   w_pressed;
    logic [7:0]             w_code;
    logic [8:0]             w_ext_code;

    // The first cycle after reset only captures the toggle level, so a stale
    // toggle value cannot look like a fresh event.
    assign w_event    = r_armed & (ps2_key[10] ^ r_toggle_q);
    assign w_pressed  = ps2_key[9];
    assign w_code     = ps2_key[7:0];
    assign w_ext_code = ps2_key[8:0];

    // Track the toggle bit and arm event detection after the first cycle
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_toggle_q <= 1'b0;
            r_armed    <= 1'b0;
        end else begin
            r_toggle_q <= ps2_key[10];
            r_armed    <= 1'b1;
        end
    end

    // Update the held state of the matching key on each event
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_key_state <= '0;
        end else if (w_event) begin
            if (w_code == c_sc_up)         r_key_state[c_key_up]    <= w_pressed;
            if (w_code == c_sc_down)       r_key_state[c_key_down]  <= w_pressed;
            if (w_code == c_sc_left)       r_key_state[c_key_left]  <= w_pressed;
            if (w_code == c_sc_right)      r_key_state[c_key_right] <= w_pressed;
            if (w_code == c_sc_ctrl)       r_key_state[c_key_ctrl]  <= w_pressed;
            if (w_ext_code == c_sc_space)  r_key_state[c_key_space] <= w_pressed;
            if (w_ext_code == c_sc_f1)     r_key_state[c_key_f1]    <= w_pressed;
            if (w_ext_code == c_sc_f2)     r_key_state[c_key_f2]    <= w_pressed;
        end
    end

    assign key_state = r_key_state;

`ifdef ARCADE_AUTOFIRE_EN
    // Only the press event of F3 matters; releases are ignored
    assign f3_press = w_event & w_pressed & (w_ext_code == c_sc_f3);
`endif

endmodule
`default_nettype wire

// File: rtl/arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : arcade_input_ctrl
// Description : Maps PS/2 keys and two joysticks onto arcade game controls
//               and turns a start request into a coin pulse, a gap and a
//               player-start pulse. Optional autofire when the macro
//               ARCADE_AUTOFIRE_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int COIN_CYCLES     = 1100000,
    parameter int GAP_CYCLES      = 550000,
    parameter int START_CYCLES    = 550000,
    parameter int AUTOFIRE_CYCLES = 550000
) (
    input  wire logic          clk_sys,
    input  wire logic          reset_n,
    arcade_input_ctrl_if.slave bus
);

    localparam int c_max_cycles = max_of(max_of(COIN_CYCLES, GAP_CYCLES), START_CYCLES);
    localparam int c_cnt_w      = $clog2(c_max_cycles) + 1;

    localparam logic [c_cnt_w-1:0] c_coin_load  = c_cnt_w'(COIN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load   = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_start_load = c_cnt_w'(START_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    logic [c_key_count-1:0] w_keys;
    logic [15:0]            w_joy;
    logic                   w_left;
    logic                   w_right;
    logic                   w_barrier;
    logic                   w_fire_req;
    logic                   w_start1_req;
    logic                   w_start2_req;
    logic                   w_unused_joy;

    logic                   r_btn_left;
    logic                   r_btn_right;
    logic                   r_btn_barrier;
    logic                   r_btn_fire;

    seq_state_t             r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [1:0]             r_player;
    logic                   r_btn_coin;
    logic [1:0]             r_btn_player_start;
    logic                   r_seq_busy;

`ifdef ARCADE_AUTOFIRE_EN
    logic                   w_f3_press;
`endif

    arcade_ps2_keys u_keys (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .ps2_key   (bus.ps2_key),
`ifdef ARCADE_AUTOFIRE_EN
        .f3_press  (w_f3_press),
`endif
        .key_state (w_keys)
    );

    assign w_joy        = bus.joystick_0 | bus.joystick_1;
    assign w_unused_joy = ^w_joy[15:8];

    // Rotated cabinets steer with up/down instead of left/right
    assign w_left  = bus.rotate ? (w_keys[c_key_down] | w_joy[c_joy_down])
                                : (w_keys[c_key_left] | w_joy[c_joy_left]);
    assign w_right = bus.rotate ? (w_keys[c_key_up]    | w_joy[c_joy_up])
                                : (w_keys[c_key_right] | w_joy[c_joy_right]);

    assign w_barrier    = w_keys[c_key_ctrl]  | w_joy[c_joy_barrier];
    assign w_fire_req   = w_keys[c_key_space] | w_joy[c_joy_fire];
    assign w_start1_req = w_keys[c_key_f1]    | w_joy[c_joy_start1];
    assign w_start2_req = w_keys[c_key_f2]    | w_joy[c_joy_start2];

    // Register the directional and barrier controls
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_left    <= 1'b0;
            r_btn_right   <= 1'b0;
            r_btn_barrier <= 1'b0;
        end else begin
            r_btn_left    <= w_left;
            r_btn_right   <= w_right;
            r_btn_barrier <= w_barrier;
        end
    end

`ifdef ARCADE_AUTOFIRE_EN
    localparam int c_af_w = $clog2(AUTOFIRE_CYCLES) + 1;

    localparam logic [c_af_w-1:0] c_af_half = c_af_w'(AUTOFIRE_CYCLES / 2);
    localparam logic [c_af_w-1:0] c_af_last = c_af_w'(AUTOFIRE_CYCLES - 1);
    localparam logic [c_af_w-1:0] c_af_one  = c_af_w'(1);

    logic                   r_autofire_on;
    logic                   r_fire_req_d;
    logic [c_af_w-1:0]      r_phase_cnt;
    logic                   w_fire_rise;
    logic [c_af_w-1:0]      w_phase_idx;

    // A fresh press always starts in the high half of the period
    assign w_fire_rise = w_fire_req & ~r_fire_req_d;
    assign w_phase_idx = w_fire_rise ? '0 : r_phase_cnt;

    // Autofire enable toggle, phase counter and gated fire output
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_autofire_on <= 1'b0;
            r_fire_req_d  <= 1'b0;
            r_phase_cnt   <= '0;
            r_btn_fire    <= 1'b0;
        end else begin
            if (w_f3_press) begin
                r_autofire_on <= ~r_autofire_on;
            end
            r_fire_req_d <= w_fire_req;
            r_phase_cnt  <= (w_phase_idx == c_af_last) ? '0 : (w_phase_idx + c_af_one);
            r_btn_fire   <= r_autofire_on ? (w_fire_req & (w_phase_idx < c_af_half))
                                          : w_fire_req;
        end
    end
`else
    // Fire follows the request directly
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_btn_fire <= 1'b0;
        end else begin
            r_btn_fire <= w_fire_req;
        end
    end
`endif

    // Coin/start sequencer sharing one down-counter reloaded on state entry
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state            <= ST_IDLE;
            r_cnt              <= '0;
            r_player           <= 2'b00;
            r_btn_coin         <= 1'b0;
            r_btn_player_start <= 2'b00;
            r_seq_busy         <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start1_req | w_start2_req) begin
                        r_player   <= w_start1_req ? 2'b01 : 2'b10;
                        r_state    <= ST_COIN;
                        r_cnt      <= c_coin_load;
                        r_btn_coin <= 1'b1;
                        r_seq_busy <= 1'b1;
                    end
                end
                ST_COIN: begin
                    if (r_cnt == '0) begin
                        r_state    <= ST_GAP;
                        r_cnt      <= c_gap_load;
                        r_btn_coin <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        r_state            <= ST_START;
                        r_cnt              <= c_start_load;
                        r_btn_player_start <= r_player;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_START: begin
                    if (r_cnt == '0) begin
                        r_state            <= ST_RELEASE;
                        r_cnt              <= '0;
                        r_btn_player_start <= 2'b00;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                ST_RELEASE: begin
                    // Wait for both requests to drop so a held button fires once
                    if (!w_start1_req && !w_start2_req) begin
                        r_state    <= ST_IDLE;
                        r_cnt      <= '0;
                        r_seq_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state            <= ST_IDLE;
                    r_cnt              <= '0;
                    r_btn_coin         <= 1'b0;
                    r_btn_player_start <= 2'b00;
                    r_seq_busy         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_left         = r_btn_left;
    assign bus.btn_right        = r_btn_right;
    assign bus.btn_fire         = r_btn_fire;
    assign bus.btn_barrier      = r_btn_barrier;
    assign bus.btn_coin         = r_btn_coin;
    assign bus.btn_player_start = r_btn_player_start;
    assign bus.seq_busy         = r_seq_busy;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_arcade_input_ctrl
// Description : Directed self-checking bench for arcade_input_ctrl with short
//               sequencer and autofire timing.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_ctrl;

    localparam int COIN  = 10;
    localparam int GAP   = 5;
    localparam int START = 8;
    localparam int AF    = 8;

    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if ifc ();

    arcade_input_ctrl #(
        .COIN_CYCLES     (COIN),
        .GAP_CYCLES      (GAP),
        .START_CYCLES    (START),
        .AUTOFIRE_CYCLES (AF)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (ifc.slave)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        ifc.ps2_key = {~ifc.ps2_key[10], pressed, code};
    endtask

    // {busy, coin, start[1:0], left, right, fire, barrier}
    function automatic logic [7:0] snap();
        return {ifc.seq_busy, ifc.btn_coin, ifc.btn_player_start,
                ifc.btn_left, ifc.btn_right, ifc.btn_fire, ifc.btn_barrier};
    endfunction

    // Request already driven; window k=0 is the edge that enters COIN
    task automatic seq_window(input string tag, input logic [1:0] player, input int n);
        logic [7:0] e;
        for (int k = 0; k < n; k++) begin
            tick();
            e = 8'b1000_0000;
            if (k < COIN) e[6] = 1'b1;
            if (k >= COIN + GAP && k < COIN + GAP + START) e[5:4] = player;
            check_eq($sformatf("%s k=%0d", tag, k), {24'd0, snap()}, {24'd0, e});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nz;
        logic exp_fire;
        ifc.ps2_key    = '0;
        ifc.joystick_0 = '0;
        ifc.joystick_1 = '0;
        ifc.rotate     = 1'b0;

        tick();
        tick();
        check_eq("reset_outputs", {24'd0, snap()}, 32'd0);
        reset_n = 1'b1;
        tick();
        tick();
        check_eq("idle_after_reset", {24'd0, snap()}, 32'd0);

        // Left key press/release, rotate=0
        send_key(1'b1, 9'h06B);
        tick();
        check_eq("left_press_lat", {31'd0, ifc.btn_left}, 32'd0);
        tick();
        check_eq("left_press", {31'd0, ifc.btn_left}, 32'd1);
        send_key(1'b0, 9'h06B);
        tick();
        check_eq("left_release_lat", {31'd0, ifc.btn_left}, 32'd1);
        tick();
        check_eq("left_release", {31'd0, ifc.btn_left}, 32'd0);

        // Extended code on a direction key still counts
        send_key(1'b1, 9'h174);
        tick(); tick();
        check_eq("ext_right_press", {31'd0, ifc.btn_right}, 32'd1);
        send_key(1'b0, 9'h174);
        tick(); tick();
        check_eq("ext_right_release", {31'd0, ifc.btn_right}, 32'd0);

        // Rotation remap
        ifc.rotate     = 1'b1;
        ifc.joystick_1 = 16'h0008;
        tick();
        check_eq("rot_up_is_right", {31'd0, ifc.btn_right}, 32'd1);
        ifc.joystick_1 = 16'h0001;
        tick();
        check_eq("rot_right_ignored", {31'd0, ifc.btn_right}, 32'd0);
        ifc.joystick_1 = 16'h0004;
        tick();
        check_eq("rot_down_is_left", {31'd0, ifc.btn_left}, 32'd1);
        ifc.joystick_1 = 16'h0000;
        ifc.rotate     = 1'b0;
        ifc.joystick_0 = 16'h0001;
        tick();
        check_eq("norot_right", {24'd0, snap()}, 32'h04);
        ifc.joystick_0 = 16'h0000;
        tick();
        check_eq("all_idle", {24'd0, snap()}, 32'd0);

        // Barrier from extended ctrl and from joystick
        send_key(1'b1, 9'h114);
        tick(); tick();
        check_eq("ctrl_barrier", {24'd0, snap()}, 32'h01);
        send_key(1'b0, 9'h114);
        tick(); tick();
        check_eq("ctrl_barrier_off", {31'd0, ifc.btn_barrier}, 32'd0);
        ifc.joystick_1 = 16'h0020;
        tick();
        check_eq("joy_barrier", {31'd0, ifc.btn_barrier}, 32'd1);
        ifc.joystick_1 = 16'h0000;
        tick();

        // Fire: space held 32 cycles (autofire enabled by F3 when built in)
`ifdef ARCADE_AUTOFIRE_EN
        send_key(1'b1, 9'h004);
        tick();
        send_key(1'b0, 9'h004);
        tick();
`endif
        send_key(1'b1, 9'h029);
        tick();
        check_eq("fire_lat", {31'd0, ifc.btn_fire}, 32'd0);
        for (int k = 0; k < 32; k++) begin
            tick();
`ifdef ARCADE_AUTOFIRE_EN
            exp_fire = ((k % AF) < (AF / 2));
`else
            exp_fire = 1'b1;
`endif
            check_eq($sformatf("fire k=%0d", k), {31'd0, ifc.btn_fire}, {31'd0, exp_fire});
        end
        send_key(1'b0, 9'h029);
        tick(); tick();
        check_eq("fire_release", {31'd0, ifc.btn_fire}, 32'd0);

        // Sequencer: start2 held 100 cycles, one sequence only
        ifc.joystick_0 = 16'h0080;
        seq_window("seq_p2", 2'b10, 100);
        ifc.joystick_0 = 16'h0000;
        tick();
        check_eq("seq_p2_busy_drop", {24'd0, snap()}, 32'd0);
        nz = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (snap() != 8'd0) nz++;
        end
        check_eq("seq_p2_single", nz, 32'd0);

        // Both starts in the same cycle: player 1 wins
        ifc.joystick_0 = 16'h0040;
        ifc.joystick_1 = 16'h0080;
        seq_window("seq_both", 2'b01, 30);
        ifc.joystick_0 = 16'h0000;
        ifc.joystick_1 = 16'h0000;
        tick();
        check_eq("seq_both_done", {31'd0, ifc.seq_busy}, 32'd0);

        // Keyboard F2 start
        send_key(1'b1, 9'h006);
        tick();
        check_eq("kbd_f2_lat", {24'd0, snap()}, 32'd0);
        seq_window("seq_kbd_f2", 2'b10, 30);
        send_key(1'b0, 9'h006);
        tick();
        check_eq("kbd_f2_rel_lat", {31'd0, ifc.seq_busy}, 32'd1);
        tick();
        check_eq("kbd_f2_done", {31'd0, ifc.seq_busy}, 32'd0);

        // Extended F2 must not start anything
        send_key(1'b1, 9'h106);
        tick(); tick(); tick();
        check_eq("ext_f2_ignored", {24'd0, snap()}, 32'd0);
        send_key(1'b0, 9'h106);
        tick();

        // Reset during COIN aborts immediately
        ifc.joystick_0 = 16'h0040;
        tick(); tick(); tick();
        check_eq("coin_before_rst", {31'd0, ifc.btn_coin}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("rst_coin_abort", {24'd0, snap()}, 32'd0);
        ifc.joystick_0 = 16'h0000;
        tick();
        reset_n = 1'b1;
        nz = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (snap() != 8'd0) nz++;
        end
        check_eq("idle_after_abort", nz, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arcade_input_ctrl.md
ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 Parameter COIN_CYCLES, 1100000, btn_coin pulse length in clk_sys cycles (100 ms at 11 MHz).
REQ-002 Parameter GAP_CYCLES, 550000, low gap between coin pulse and start pulse.
REQ-003 Parameter START_CYCLES, 550000, btn_player_start pulse length.
REQ-004 Parameter AUTOFIRE_CYCLES, 550000, autofire full period; high for the first half, low for the second.
REQ-005 clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-006 reset_n  in  1  asynchronous, active-low reset.
REQ-007 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
REQ-008 joystick_0, joystick_1  in  16 each  [0] right, [1] left, [2] down, [3] up, [4] fire, [5] barrier, [6] start1, [7] start2.
REQ-009 rotate  in  1  1 = horizontal orientation remap.
REQ-010 btn_left, btn_right, btn_fire, btn_barrier, btn_coin  out  1 each  game controls, active-high.
REQ-011 btn_player_start  out  2  [0] 1P, [1] 2P.
REQ-012 seq_busy  out  1  high whenever the coin/start sequencer is not in IDLE.

Function
REQ-013 Key event: ps2_key[10] differs from its registered copy; the registered copy is loaded from ps2_key[10] in the first cycle after reset release, with no event in that cycle.
REQ-014 On each event, the matching key-state bit takes ps2_key[9]: up 0x75, down 0x72, left 0x6B, right 0x74, ctrl 0x14 (bit 8 ignored for all five); space 0x029, F1 0x005, F2 0x006 (bit 8 = 0 only).
REQ-015 joy = joystick_0 | joystick_1; all control outputs are registered with exactly 1 cycle latency from key state or joy.
REQ-016 rotate=0: left = key_left | joy[1]; right = key_right | joy[0]. rotate=1: left = key_down | joy[2]; right = key_up | joy[3].
REQ-017 barrier = key_ctrl | joy[5]; fire_req = key_space | joy[4].
REQ-018 start1_req = key_F1 | joy[6]; start2_req = key_F2 | joy[7].
REQ-019 Sequencer states: IDLE -> COIN -> GAP -> START -> RELEASE -> IDLE.
REQ-020 IDLE: the first cycle with start1_req | start2_req high enters COIN and latches the player; start1 wins if both are high.
REQ-021 COIN: btn_coin=1 for exactly COIN_CYCLES cycles. GAP: all outputs 0 for GAP_CYCLES cycles. START: the latched btn_player_start bit is 1 for START_CYCLES cycles.
REQ-022 RELEASE: stay until start1_req and start2_req are both 0, then return to IDLE.
REQ-023 Start requests outside IDLE are ignored; a request held continuously produces exactly one sequence.
REQ-024 A single shared down-counter is used, of width $clog2 of the largest cycle parameter plus 1; it reloads on every state entry.

Reset
REQ-025 While reset_n=0, all outputs are 0, all key-state bits are 0, the sequencer is in IDLE, and the counter and autofire state are 0.
REQ-026 Reset asserted mid-sequence aborts the sequence immediately with no residual pulse.

Configuration
REQ-027 With ARCADE_AUTOFIRE_EN defined:
- An F3 press event (0x004, pressed=1) toggles autofire_on.
- When autofire_on=1, btn_fire = fire_req & phase, where phase is high for the first AUTOFIRE_CYCLES/2 cycles of each period.
- The phase counter restarts at the rising edge of fire_req.
REQ-028 Without ARCADE_AUTOFIRE_EN: btn_fire = fire_req, F3 is ignored, and no autofire logic is synthesised.

Structure
REQ-029 Package arcade_input_pkg holds the scancode constants, the joystick bit-index constants, and the sequencer state enum.
REQ-030 Sub-module arcade_ps2_keys performs event detection and key-state decode (REQ-013/014) and outputs a key-state vector.

Verification
REQ-031 Press 0x06B, then release 0x06B, with rotate=0 -> btn_left goes 1 one cycle after the press toggle and 0 one cycle after the release toggle.
REQ-032 rotate=1 and joystick_1[3]=1 -> btn_right=1; with joystick_1[0]=1 alone -> btn_right=0.
REQ-033 Sequencer timing with COIN=10, GAP=5, START=8; hold joy[7] for 100 cycles ->
- btn_coin high 10 cycles;
- then 5 cycles with all outputs 0;
- then btn_player_start=2'b10 for 8 cycles;
- seq_busy stays high until 1 cycle after joy[7] drops;
- only one sequence occurs.
REQ-034 F1 and F2 pressed in the same cycle -> btn_player_start=2'b01 only.
REQ-035 reset_n pulsed low during COIN -> btn_coin=0 immediately; after release with no requests, the sequencer stays in IDLE.
REQ-036 ARCADE_AUTOFIRE_EN, AUTOFIRE_CYCLES=8, F3 pressed, space held 32 cycles -> btn_fire shows 4 periods of 4 high / 4 low; macro undefined -> btn_fire steady high.
